// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: writeback request/grant bundle between the result sources and the arbiter
interface wb_port_arbiter_if;
    logic [3:0] req;
    logic [4:0] dest0;
    logic [4:0] dest1;
    logic [4:0] dest2;
    logic [4:0] dest3;
    logic [3:0] ack;
    logic [1:0] wb_sel;
    logic       wb_en;
    logic [4:0] wb_addr;
    logic       stall0;
    modport master (output req, dest0, dest1, dest2, dest3, input ack, wb_sel, wb_en, wb_addr, stall0);
    modport slave  (input req, dest0, dest1, dest2, dest3, output ack, wb_sel, wb_en, wb_addr, stall0);
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: four-source register-file writeback port arbiter with starvation guard
module wb_port_arbiter #(
    parameter bit PRIO0        = 1'b1,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input logic              clock,
    input logic              reset,
    wb_port_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    logic [3:0]       ack_q, ack_d;
    logic [1:0]       sel_q, sel_d;
    logic             en_q, en_d;
    logic [4:0]       addr_q, addr_d;
    logic [1:0]       rr_q, rr_d;
    logic [CNT_W-1:0] wcnt_q [4];
    logic [CNT_W-1:0] wcnt_d [4];
    logic [4:0]       dest [4];
    logic [3:0]       elig, starved;
    logic             win_v;
    logic [1:0]       win;
    assign elig = bus.req & ~ack_q;
    // gather the per-source destinations so the winner can index them
    always_comb begin
        dest[0] = bus.dest0;
        dest[1] = bus.dest1;
        dest[2] = bus.dest2;
        dest[3] = bus.dest3;
    end
    // a source is starved once it has waited the limit while eligible
    always_comb begin
        for (int i = 0; i < 4; i++) starved[i] = elig[i] && (wcnt_q[i] >= LIMIT);
    end
    // pick the winner: starved lowest index, then source 0 priority, then round-robin from rr_q
    always_comb begin
        win_v = |elig;
        win   = 2'd0;
        if (|starved)
            win = starved[0] ? 2'd0 : starved[1] ? 2'd1 : starved[2] ? 2'd2 : 2'd3;
        else if (!(PRIO0 && elig[0]))
            for (int j = 3; j >= 0; j--) if (elig[rr_q + 2'(j)]) win = rr_q + 2'(j);
    end
    // next registered outputs, pointer and wait counters
    always_comb begin
        ack_d  = win_v ? 4'b0001 << win : 4'b0000;
        sel_d  = win_v ? win : sel_q;
        addr_d = win_v ? dest[win] : addr_q;
        en_d   = win_v && (dest[win] != 5'd0);
        rr_d   = win_v ? win + 2'd1 : rr_q;
        for (int i = 0; i < 4; i++)
            wcnt_d[i] = ((win_v && win == 2'(i)) || !bus.req[i]) ? '0 :
                        elig[i] ? ((wcnt_q[i] >= LIMIT) ? LIMIT : wcnt_q[i] + 1'b1) : wcnt_q[i];
    end
    // state registers; reset drops any pending ack immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_q  <= 4'b0000;
            sel_q  <= 2'd0;
            en_q   <= 1'b0;
            addr_q <= 5'd0;
            rr_q   <= 2'd0;
            wcnt_q <= '{default: '0};
        end else begin
            ack_q  <= ack_d;
            sel_q  <= sel_d;
            en_q   <= en_d;
            addr_q <= addr_d;
            rr_q   <= rr_d;
            wcnt_q <= wcnt_d;
        end
    end
    assign bus.ack     = ack_q;
    assign bus.wb_sel  = sel_q;
    assign bus.wb_en   = en_q;
    assign bus.wb_addr = addr_q;
    assign bus.stall0  = bus.req[0] && !(win_v && win == 2'd0);
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and randomized checks of both priority modes against a rule-level model
module tb_wb_port_arbiter;
    localparam int LIMIT = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    wb_port_arbiter_if ifa ();
    wb_port_arbiter_if ifb ();
    wb_port_arbiter #(.PRIO0(1'b1), .STARVE_LIMIT(LIMIT), .CNT_W(4)) dut_a (.clock(clk), .reset(rst), .bus(ifa));
    wb_port_arbiter #(.PRIO0(1'b0), .STARVE_LIMIT(LIMIT), .CNT_W(4)) dut_b (.clock(clk), .reset(rst), .bus(ifb));
    int checks = 0;
    int errors = 0;
    int prio [2] = '{1, 0};
    int m_ack [2], m_sel [2], m_en [2], m_addr [2], m_rr [2];
    int m_wait [2][4];
    logic [3:0] cur_req;
    logic [4:0] cur_dest [4];
    int exp_stall [2];
    logic got_stall [2], got_en [2];
    logic [3:0] got_ack [2];
    logic [1:0] got_sel [2];
    logic [4:0] got_addr [2];

    function automatic bit is_elig(int k, int i);
        return cur_req[i] && (m_ack[k] != (1 << i));
    endfunction

    function automatic int pick(int k);
        for (int i = 0; i < 4; i++) if (is_elig(k, i) && m_wait[k][i] >= LIMIT) return i;
        if (prio[k] == 1 && is_elig(k, 0)) return 0;
        for (int j = 0; j < 4; j++) if (is_elig(k, (m_rr[k] + j) % 4)) return (m_rr[k] + j) % 4;
        return -1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ack[k] = 0; m_sel[k] = 0; m_en[k] = 0; m_addr[k] = 0; m_rr[k] = 0;
            for (int i = 0; i < 4; i++) m_wait[k][i] = 0;
        end
    endfunction

    function automatic void model_edge(int k);
        int w = pick(k);
        for (int i = 0; i < 4; i++)
            if (i == w || !cur_req[i]) m_wait[k][i] = 0;
            else if (is_elig(k, i)) m_wait[k][i] = (m_wait[k][i] + 1 > LIMIT) ? LIMIT : m_wait[k][i] + 1;
        if (w >= 0) begin
            m_ack[k] = 1 << w; m_sel[k] = w; m_addr[k] = int'(cur_dest[w]);
            m_en[k] = (cur_dest[w] != 0) ? 1 : 0; m_rr[k] = (w + 1) % 4;
        end else begin
            m_ack[k] = 0; m_en[k] = 0;
        end
    endfunction

    task automatic cyc(input logic [3:0] r, input logic [4:0] d0, input logic [4:0] d1, input logic [4:0] d2, input logic [4:0] d3);
        cur_req = r;
        cur_dest = '{d0, d1, d2, d3};
        ifa.req = r; ifa.dest0 = d0; ifa.dest1 = d1; ifa.dest2 = d2; ifa.dest3 = d3;
        ifb.req = r; ifb.dest0 = d0; ifb.dest1 = d1; ifb.dest2 = d2; ifb.dest3 = d3;
        #2;
        got_stall[0] = ifa.stall0;
        got_stall[1] = ifb.stall0;
        for (int k = 0; k < 2; k++) exp_stall[k] = (r[0] && pick(k) != 0) ? 1 : 0;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        got_ack[0] = ifa.ack; got_sel[0] = ifa.wb_sel; got_en[0] = ifa.wb_en; got_addr[0] = ifa.wb_addr;
        got_ack[1] = ifb.ack; got_sel[1] = ifb.wb_sel; got_en[1] = ifb.wb_en; got_addr[1] = ifb.wb_addr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.req = 4'b0001; ifb.req = 4'b0001;
        #1;
        checks++;
        if (ifa.ack !== 4'b0 || ifa.wb_sel !== 2'b0 || ifa.wb_en !== 1'b0 || ifa.wb_addr !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b sel=%b en=%b addr=%0d want all zero", ifa.ack, ifa.wb_sel, ifa.wb_en, ifa.wb_addr);
        end
        checks++;
        if (ifa.stall0 !== 1'b0 || ifb.stall0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall0: got a=%b b=%b want 0", ifa.stall0, ifb.stall0);
        end
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] exp_ack [2] = '{4'b0001, 4'b0000};
        logic exp_en [2] = '{1'b1, 1'b0};
        do_reset();
        for (int c = 0; c < 2; c++) begin
            cyc(c == 0 ? 4'b0001 : 4'b0000, 5'd5, 5'd0, 5'd0, 5'd0);
            checks++;
            if (got_ack[0] !== exp_ack[c] || got_sel[0] !== 2'd0 || got_en[0] !== exp_en[c] || got_addr[0] !== 5'd5 || got_stall[0] !== 1'b0) begin
                errors++;
                $display("FAIL single_c%0d: got ack=%b sel=%0d en=%b addr=%0d stall0=%b want ack=%b sel=0 en=%b addr=5 stall0=0",
                         c, got_ack[0], got_sel[0], got_en[0], got_addr[0], got_stall[0], exp_ack[c], exp_en[c]);
            end
        end
    endtask

    task automatic test_rotate();
        logic [3:0] exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            cyc(4'b1111 & ~ifb.ack, 5'd1, 5'd2, 5'd3, 5'd4);
            checks++;
            if (got_ack[1] !== exp_ack[c] || got_sel[1] !== exp_sel[c] || got_addr[1] !== 5'(exp_sel[c] + 1)) begin
                errors++;
                $display("FAIL rotate_c%0d: got ack=%b sel=%0d addr=%0d want ack=%b sel=%0d addr=%0d",
                         c, got_ack[1], got_sel[1], got_addr[1], exp_ack[c], exp_sel[c], exp_sel[c] + 1);
            end
        end
    endtask

    task automatic test_starve();
        logic [3:0] exp_ack [6] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b1000, 4'b0001};
        logic exp_st [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            cyc(4'b1101, 5'(c + 10), 5'd0, 5'd7, 5'd9);
            checks++;
            if (got_ack[0] !== exp_ack[c] || got_stall[0] !== exp_st[c]) begin
                errors++;
                $display("FAIL starve_c%0d: got ack=%b stall0=%b want ack=%b stall0=%b", c, got_ack[0], got_stall[0], exp_ack[c], exp_st[c]);
            end
        end
    endtask

    task automatic test_r0_write();
        do_reset();
        cyc(4'b0100, 5'd3, 5'd3, 5'd0, 5'd3);
        checks++;
        if (got_ack[0] !== 4'b0100 || got_sel[0] !== 2'b10 || got_addr[0] !== 5'd0 || got_en[0] !== 1'b0) begin
            errors++;
            $display("FAIL r0_write: got ack=%b sel=%b addr=%0d en=%b want ack=0100 sel=10 addr=0 en=0", got_ack[0], got_sel[0], got_addr[0], got_en[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ack [3] = '{4'b0010, 4'b0000, 4'b0010};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            cyc(4'b0010, 5'd0, 5'd17, 5'd0, 5'd0);
            checks++;
            if (got_ack[0] !== exp_ack[c] || got_en[0] !== (exp_ack[c] != 0) || got_addr[0] !== 5'd17) begin
                errors++;
                $display("FAIL hold_past_ack_c%0d: got ack=%b en=%b addr=%0d want ack=%b addr=17", c, got_ack[0], got_en[0], got_addr[0], exp_ack[c]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(4'b1000, 5'd0, 5'd0, 5'd0, 5'd9);
        checks++;
        if (got_ack[0] !== 4'b1000 || got_en[0] !== 1'b1 || got_sel[0] !== 2'd3 || got_addr[0] !== 5'd9) begin
            errors++;
            $display("FAIL async_pre: got ack=%b en=%b sel=%0d addr=%0d want 1000 1 3 9", got_ack[0], got_en[0], got_sel[0], got_addr[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ifa.ack !== 4'b0 || ifa.wb_en !== 1'b0 || ifa.wb_sel !== 2'b0 || ifa.wb_addr !== 5'b0) begin
            errors++;
            $display("FAIL async_clear: got ack=%b en=%b sel=%0d addr=%0d want all zero", ifa.ack, ifa.wb_en, ifa.wb_sel, ifa.wb_addr);
        end
        model_reset();
        #1;
        rst = 1'b0;
        cyc(4'b1000, 5'd0, 5'd0, 5'd0, 5'd9);
        checks++;
        if (got_ack[0] !== 4'b1000 || got_en[0] !== 1'b1 || got_sel[0] !== 2'd3 || got_addr[0] !== 5'd9) begin
            errors++;
            $display("FAIL async_regrant: got ack=%b en=%b sel=%0d addr=%0d want 1000 1 3 9", got_ack[0], got_en[0], got_sel[0], got_addr[0]);
        end
    endtask

    task automatic test_random();
        logic [4:0] d [4];
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) d[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cyc(4'($urandom_range(0, 15)) | ((c % 16 < 8) ? 4'b0001 : 4'b0000), d[0], d[1], d[2], d[3]);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_ack[k] !== 4'(m_ack[k]) || got_sel[k] !== 2'(m_sel[k]) || got_en[k] !== 1'(m_en[k]) ||
                    got_addr[k] !== 5'(m_addr[k]) || got_stall[k] !== 1'(exp_stall[k])) begin
                    errors++;
                    $display("FAIL random_c%0d_dut%0d: got ack=%b sel=%0d en=%b addr=%0d stall0=%b want ack=%b sel=%0d en=%0d addr=%0d stall0=%0d",
                             c, k, got_ack[k], got_sel[k], got_en[k], got_addr[k], got_stall[k],
                             4'(m_ack[k]), m_sel[k], m_en[k], m_addr[k], exp_stall[k]);
                end
            end
        end
    endtask

    initial begin
        ifa.req = 4'b0; ifa.dest0 = 5'd0; ifa.dest1 = 5'd0; ifa.dest2 = 5'd0; ifa.dest3 = 5'd0;
        ifb.req = 4'b0; ifb.dest0 = 5'd0; ifb.dest1 = 5'd0; ifb.dest2 = 5'd0; ifb.dest3 = 5'd0;
        cur_req = 4'b0;
        cur_dest = '{5'd0, 5'd0, 5'd0, 5'd0};
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_rotate();
        test_starve();
        test_r0_write();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
